// File: rtl/copy_sched_pkg.sv
// rtl/copy_sched_pkg.sv - shared encodings and defaults for copy_job_scheduler (optional SCHED_TIMEOUT_EN)
package copy_sched_pkg;

    localparam int DEF_NREQ    = 2;
    localparam int DEF_NWRITES = 10;
    localparam int DEF_TIMEOUT = 31;
    localparam int BANK_W      = 2;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_START = 5'b00010,
        S_RUN   = 5'b00100,
`ifdef SCHED_TIMEOUT_EN
        S_ABORT = 5'b10000,
`endif
        S_ACK   = 5'b01000
    } state_t;

endpackage

// File: rtl/copy_job_scheduler_rr_arbiter.sv
// rtl/copy_job_scheduler_rr_arbiter.sv - combinational round-robin pick starting after ptr
module rr_arbiter
    import copy_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]   req,
    input  logic [BANK_W-1:0] ptr,
    output logic [NREQ-1:0]   gnt,
    output logic [BANK_W-1:0] idx,
    output logic              any
);

    logic [BANK_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // Scan ptr+1 .. ptr+NREQ so the last owner is considered last.
        for (int i = 1; i <= NREQ; i++) begin
            cand = BANK_W'((int'(ptr) + i) % NREQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/copy_job_scheduler.sv
// rtl/copy_job_scheduler.sv - shares one copy engine among NREQ requesters; SCHED_TIMEOUT_EN adds RUN watchdog/abort
module copy_job_scheduler
    import copy_sched_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int NWRITES = DEF_NWRITES,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NREQ-1:0]   Req,
    output logic [NREQ-1:0]   Grant,
    output logic [BANK_W-1:0] Bank,
    output logic              Busy,
    output logic [NREQ-1:0]   ReqDone,
    output logic              EngStart,
    output logic              EngAck,
    input  logic              EngWrite,
    output logic              EngAbort,
    output logic              Err
);

    localparam int WCNT_W = $clog2(NWRITES + 1);

    if (NREQ < 2 || NREQ > 4 || NWRITES < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("copy_job_scheduler: illegal parameter value");
    end

    state_t            state, state_nx;
    logic [NREQ-1:0]   owner_oh;
    logic [BANK_W-1:0] rrptr;
    logic [WCNT_W-1:0] wcnt;
    logic [NREQ-1:0]   win_gnt;
    logic [BANK_W-1:0] win_idx;
    logic              win_any;
    logic              job_end;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (Req),
        .ptr (rrptr),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

`ifdef SCHED_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tcnt <= '0;
        end else if (state == S_START) begin
            tcnt <= '0;
        end else if (state == S_RUN) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign job_end  = (state == S_ACK) || (state == S_ABORT);
    assign EngAbort = (state == S_ABORT);
    assign Err      = (state == S_ABORT);
`else
    assign job_end  = (state == S_ACK);
    assign EngAbort = 1'b0;
    assign Err      = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (win_any) state_nx = S_START;
            S_START: state_nx = S_RUN;
            S_RUN: begin
                // Completion wins over a timeout landing on the same edge.
                if (EngWrite && wcnt == WCNT_W'(NWRITES - 1)) begin
                    state_nx = S_ACK;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    state_nx = S_ABORT;
                end
`endif
            end
            S_ACK:   state_nx = S_IDLE;
`ifdef SCHED_TIMEOUT_EN
            S_ABORT: state_nx = S_IDLE;
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            owner_oh <= '0;
            Bank     <= '0;
            wcnt     <= '0;
            rrptr    <= BANK_W'(NREQ - 1);
        end else begin
            state <= state_nx;
            if (state == S_IDLE && win_any) begin
                owner_oh <= win_gnt;
                Bank     <= win_idx;
                wcnt     <= '0;
            end
            if (state == S_RUN && EngWrite) begin
                wcnt <= wcnt + 1'b1;
            end
            if (job_end) begin
                rrptr <= Bank;
            end
        end
    end

    assign Busy     = (state != S_IDLE);
    assign Grant    = Busy ? owner_oh : '0;
    assign EngStart = (state == S_START);
    assign EngAck   = (state == S_ACK);
    assign ReqDone  = job_end ? owner_oh : '0;

endmodule
